// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory boot loader
package imem_loader_pkg;

  localparam int CNT_W = 16;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHECK,
    ST_RUN
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-in / memory-write-out bundle of the boot loader
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        imem_wr_en;
  logic [31:0] imem_wr_addr;
  logic [31:0] imem_wr_data;

  modport master (
    input  rx_data, rx_valid,
    output imem_wr_en, imem_wr_addr, imem_wr_data
  );

  modport slave (
    output rx_data, rx_valid,
    input  imem_wr_en, imem_wr_addr, imem_wr_data
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs big-endian bytes into 32-bit words
module loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [23:0] shift_q;
  logic [1:0]  idx_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      idx_q   <= idx_q + 2'd1;
    end
  end

  // The 4th byte completes the word combinationally so the top can register it on the same edge.
  assign word_valid_o = byte_valid_i && (idx_q == 2'd3);
  assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to instruction memory, holds the CPU in reset until loaded
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'd0,
  parameter int          ADDR_STEP      = 2,
  parameter int          MAX_WORDS      = 256,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_loader_if.master        bus,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 error,
  output logic [CNT_W-1:0]     words_loaded
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  words_q;
  logic [7:0]        csum_q;
  logic [TW-1:0]     timer_q;
  logic [31:0]       next_addr_q;
  logic              cpu_reset_q, done_q, error_q;
  logic              wr_en_q;
  logic [31:0]       wr_addr_q, wr_data_q;

  logic              timing;
  logic              timeout;
  logic              asm_clear;
  logic              asm_valid;
  logic              word_valid;
  logic [31:0]       word;
  logic [CNT_W-1:0]  len_n;

  always_comb begin
    timing    = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                (state_q == ST_DATA)   || (state_q == ST_CHECK);
    // A byte arriving on the expiry cycle wins over the timeout.
    timeout   = timing && !bus.rx_valid && (timer_q == TMAX);
    asm_clear = (state_q != ST_DATA) || timeout;
    asm_valid = bus.rx_valid && (state_q == ST_DATA);
    len_n     = {count_q[15:8], bus.rx_data};
  end

  loader_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_valid),
    .byte_i       (bus.rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      words_q     <= '0;
      csum_q      <= '0;
      timer_q     <= '0;
      next_addr_q <= BASE_ADDR;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;

      if (bus.rx_valid || !timing)
        timer_q <= '0;
      else if (!timeout)
        timer_q <= timer_q + 1'b1;

      unique case (state_q)
        ST_IDLE, ST_RUN: begin
          if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
            state_q     <= ST_LEN_HI;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= '0;
            csum_q      <= '0;
            next_addr_q <= BASE_ADDR;
          end
        end
        ST_LEN_HI: begin
          if (bus.rx_valid) begin
            count_q[15:8] <= bus.rx_data;
            csum_q        <= csum_q ^ bus.rx_data;
            state_q       <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (bus.rx_valid) begin
            count_q <= len_n;
            csum_q  <= csum_q ^ bus.rx_data;
            if (len_n == '0 || 32'(len_n) > 32'(MAX_WORDS)) begin
              error_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (bus.rx_valid) begin
            csum_q <= csum_q ^ bus.rx_data;
            if (word_valid) begin
              wr_en_q     <= 1'b1;
              wr_addr_q   <= next_addr_q;
              wr_data_q   <= word;
              next_addr_q <= next_addr_q + 32'(ADDR_STEP);
              words_q     <= words_q + 1'b1;
              if (words_q + 1'b1 == count_q)
                state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == csum_q) begin
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
              state_q     <= ST_RUN;
            end else begin
              error_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (timeout) begin
        error_q <= 1'b1;
        state_q <= ST_IDLE;
      end
    end
  end

  assign bus.imem_wr_en   = wr_en_q;
  assign bus.imem_wr_addr = wr_addr_q;
  assign bus.imem_wr_data = wr_data_q;
  assign cpu_reset        = cpu_reset_q;
  assign done             = done_q;
  assign error            = error_q;
  assign words_loaded     = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed bench with a write scoreboard for imem_loader
module tb_imem_loader;

  localparam int TO = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_reset, done, error;
  logic [15:0] words_loaded;

  wr_t sb[$];
  int  total  = 0;
  int  passed = 0;
  int  failed = 0;

  imem_loader_if bus ();

  imem_loader #(
    .BASE_ADDR      (32'd0),
    .ADDR_STEP      (2),
    .MAX_WORDS      (256),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.imem_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        failed++;
        $error("FAIL unexpected_write: observed addr 0x%0h data 0x%0h expected no write",
               bus.imem_wr_addr, bus.imem_wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", bus.imem_wr_addr, e.addr);
        check("wr_data", bus.imem_wr_data, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb.push_back('{addr: addr, data: w});
      send_byte(w[31-8*i -: 8]);
    end
  endtask

  task automatic check_drained(input string tag);
    #1;
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic send_big_frame(input int n);
    logic [7:0]  ck;
    logic [15:0] nn;
    logic [31:0] w;
    nn = n[15:0];
    ck = nn[15:8] ^ nn[7:0];
    send_byte(8'hA5);
    send_byte(nn[15:8]);
    send_byte(nn[7:0]);
    for (int k = 0; k < n; k++) begin
      w  = 32'h1234_5678 ^ (k * 32'h9E37_79B9);
      ck = ck ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      send_word(w, k * 2);
    end
    send_byte(ck);
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_wr_en", 32'(bus.imem_wr_en), 32'd0);
    check("rst_wr_addr", bus.imem_wr_addr, 32'd0);
    check("rst_wr_data", bus.imem_wr_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Good two-word frame.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_word(32'hDEAD_BEEF, 32'd0);
    send_word(32'h0000_0001, 32'd2);
    check("good_cpu_reset_before_csum", 32'(cpu_reset), 32'd1);
    check("good_words_before_csum", 32'(words_loaded), 32'd2);
    send_byte(8'h21);
    check("good_done", 32'(done), 32'd1);
    check("good_cpu_reset", 32'(cpu_reset), 32'd0);
    check("good_error", 32'(error), 32'd0);
    check("good_words", 32'(words_loaded), 32'd2);
    check_drained("good_writes");

    // Noise in RUN is ignored.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check("run_noise_done", 32'(done), 32'd1);
    check("run_noise_cpu_reset", 32'(cpu_reset), 32'd0);
    check("run_noise_words", 32'(words_loaded), 32'd2);

    // Reload with a bad checksum.
    send_byte(8'hA5);
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'hDEAD_BEEF, 32'd0);
    send_word(32'h0000_0001, 32'd2);
    send_byte(8'h22);
    check("badck_error", 32'(error), 32'd1);
    check("badck_done", 32'(done), 32'd0);
    check("badck_cpu_reset", 32'(cpu_reset), 32'd1);
    check("badck_words", 32'(words_loaded), 32'd2);
    check_drained("badck_writes");

    // Noise in IDLE is ignored; error stays sticky.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check("idle_noise_error", 32'(error), 32'd1);
    check("idle_noise_words", 32'(words_loaded), 32'd2);

    // Zero count, then a count above MAX_WORDS.
    send_byte(8'hA5);
    check("sync_clears_error", 32'(error), 32'd0);
    send_byte(8'h00); send_byte(8'h00);
    check("n0_error", 32'(error), 32'd1);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    check("n257_error", 32'(error), 32'd1);
    check("n257_words", 32'(words_loaded), 32'd0);
    check_drained("badlen_writes");

    // Timeout exactly TO idle cycles after the last byte.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD);
    repeat (TO - 1) @(negedge clk);
    check("timeout_not_yet", 32'(error), 32'd0);
    @(negedge clk);
    check("timeout_error", 32'(error), 32'd1);
    send_byte(8'hBE); send_byte(8'hEF);
    check_drained("timeout_writes");

    // Byte on the expiry cycle wins; frame completes.
    send_byte(8'hA5);
    check("after_timeout_error_clear", 32'(error), 32'd0);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hDE);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'hAD); send_byte(8'hBE);
    sb.push_back('{addr: 32'd0, data: 32'hDEAD_BEEF});
    send_byte(8'hEF);
    send_byte(8'h23);
    check("edge_byte_done", 32'(done), 32'd1);
    check("edge_byte_error", 32'(error), 32'd0);
    check("edge_byte_words", 32'(words_loaded), 32'd1);
    check_drained("edge_byte_writes");

    // Largest accepted frame, loaded as a reload from RUN.
    send_big_frame(256);
    check("max_done", 32'(done), 32'd1);
    check("max_error", 32'(error), 32'd0);
    check("max_words", 32'(words_loaded), 32'd256);
    check_drained("max_writes");

    // Reset mid-frame after one word of two.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_word(32'hCAFE_F00D, 32'd0);
    send_byte(8'h12); send_byte(8'h34);
    check("pre_reset_words", 32'(words_loaded), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_words", 32'(words_loaded), 32'd0);
    check("midrst_wr_addr", bus.imem_wr_addr, 32'd0);
    check("midrst_wr_data", bus.imem_wr_data, 32'd0);
    send_byte(8'h56); send_byte(8'h78);
    repeat (4) @(negedge clk);
    check("midrst_wr_en", 32'(bus.imem_wr_en), 32'd0);
    check_drained("midrst_writes");
    check("midrst_still_held", 32'(cpu_reset), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
